bitwise_logic_unit: RTL and testbench

- Parametrised, multi-op successor to the fixed 32-bit combinational AND in the ALU.
- Accepts two WIDTH-bit operands and a 3-bit logic opcode through a valid/ready handshake.
- Computes the result LANE bits per cycle over WIDTH/LANE beats, which trades latency for area on the decryption datapath.
- Holds the result and flags until the consumer accepts them.

---
 rtl/bitwise_logic_unit.sv | 120 ++++++++++++
 tb/tb_bitwise_logic_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_unit.sv
// Multi-beat bitwise logic unit: applies one of seven logic ops to two WIDTH-bit
// operands LANE bits per cycle, holding the result until the consumer takes it.
module bitwise_logic_unit #(
    parameter int WIDTH = 32,
    parameter int LANE  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ctrl_op,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             result_zero,
    output logic             op_err
);
    localparam int BEATS = WIDTH / LANE;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [2:0]    OP_RSVD   = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                       state_q, state_d;
    logic [BW-1:0]                beat_q, beat_d;
    logic [2:0]                   op_q, op_d;
    logic [WIDTH-1:0]             a_q, a_d, b_q, b_d;
    logic [BEATS-1:0][LANE-1:0]   res_q, res_d;
    logic                         zero_q, zero_d, err_q, err_d;
    logic [BEATS-1:0][LANE-1:0]   a_lanes, b_lanes;

    assign a_lanes = a_q;
    assign b_lanes = b_q;

    function automatic logic [LANE-1:0] lane_op(input logic [2:0] op,
                                                input logic [LANE-1:0] a,
                                                input logic [LANE-1:0] b);
        case (op)
            3'b000:  lane_op = a & b;
            3'b001:  lane_op = a | b;
            3'b010:  lane_op = a ^ b;
            3'b011:  lane_op = ~(a & b);
            3'b100:  lane_op = ~(a | b);
            3'b101:  lane_op = ~(a ^ b);
            3'b110:  lane_op = a & ~b;
            default: lane_op = '0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = data_operandA;
                    b_d     = data_operandB;
                    op_d    = ctrl_op;
                    res_d   = '0;
                    beat_d  = '0;
                    zero_d  = 1'b0;
                    err_d   = (ctrl_op == OP_RSVD);
                    // Reserved op skips the datapath entirely.
                    state_d = (ctrl_op == OP_RSVD) ? DONE : BUSY;
                end
            end
            BUSY: begin
                res_d[beat_q] = lane_op(op_q, a_lanes[beat_q], b_lanes[beat_q]);
                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                    zero_d  = (res_d == '0);
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign data_result = res_q;
    assign result_zero = zero_q;
    assign op_err      = err_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit: directed vector table, hand-written
// corner sequences, and random ops against a whole-word reference model.
module tb_bitwise_logic_unit;
    localparam int WIDTH = 32;
    localparam int LANE  = 8;
    localparam int BEATS = WIDTH / LANE;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ctrl_op;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_result;
    logic             result_zero;
    logic             op_err;

    int n_vec = 0;
    int n_err = 0;

    bitwise_logic_unit #(.WIDTH(WIDTH), .LANE(LANE)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ctrl_op       (ctrl_op),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_result   (data_result),
        .result_zero   (result_zero),
        .op_err        (op_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
        int          hold;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return a & ~b;
            default: return 32'h0;
        endcase
    endfunction

    // Issue one op, check latency and outputs, stall `hold` cycles, then drain.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ez,
                          input logic ee, input int hold);
        int n;
        @(negedge clock);
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clock); n++; end
        chk({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; ctrl_op = op; data_operandA = a; data_operandB = b;
        @(negedge clock);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clock); n++; end
        chk({name, " latency"}, n, ee ? 32'd0 : BEATS);
        chk({name, " result"}, data_result, er);
        chk({name, " zero"}, {31'b0, result_zero}, {31'b0, ez});
        chk({name, " err"}, {31'b0, op_err}, {31'b0, ee});
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk({name, " hold valid"}, {31'b0, out_valid}, 32'd1);
            chk({name, " hold result"}, data_result, er);
            chk({name, " hold flags"}, {30'b0, result_zero, op_err}, {30'b0, ez, ee});
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk({name, " drained valid"}, {31'b0, out_valid}, 32'd0);
        chk({name, " drained ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{3'b000, 32'hF0F01234, 32'hFF00FF0F, 32'hF0001204, 1'b0, 1'b0, 5};
        vecs[1] = '{3'b010, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0, 0};
        vecs[2] = '{3'b100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
        vecs[3] = '{3'b111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1, 2};
        vecs[4] = '{3'b001, 32'h0F0F0000, 32'h00F000F0, 32'h0FFF00F0, 1'b0, 1'b0, 0};
        vecs[5] = '{3'b011, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFFFF, 1'b0, 1'b0, 0};
        vecs[6] = '{3'b101, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 1'b1, 1'b0, 0};
        vecs[7] = '{3'b110, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 0};
        vecs[8] = '{3'b110, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0};
        vecs[9] = '{3'b000, 32'h80000001, 32'h80000001, 32'h80000001, 1'b0, 1'b0, 0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ctrl_op = 3'b000;
        data_operandA = '0; data_operandB = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("reset result", data_result, 32'h0);
        chk("reset flags", {29'b0, out_valid, result_zero, op_err}, 32'h0);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].zero, vecs[i].err, vecs[i].hold);

        // Port changes and in_valid pulses during BUSY must be ignored.
        @(negedge clock);
        in_valid = 1'b1; ctrl_op = 3'b110;
        data_operandA = 32'hFFFFFFFF; data_operandB = 32'h0000FFFF;
        @(negedge clock);
        data_operandA = '0; data_operandB = '0; ctrl_op = 3'b000;
        for (int i = 0; i < BEATS; i++) begin
            chk("busy in_ready", {31'b0, in_ready}, 32'd0);
            chk("busy out_valid", {31'b0, out_valid}, 32'd0);
            if (i == BEATS - 1) in_valid = 1'b0;
            @(negedge clock);
        end
        chk("busy ignore valid", {31'b0, out_valid}, 32'd1);
        chk("busy ignore result", data_result, 32'hFFFF0000);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("busy ignore drain", {31'b0, in_ready}, 32'd1);

        // Reset on the edge that would write beat 2 of an OR.
        in_valid = 1'b1; ctrl_op = 3'b001;
        data_operandA = 32'h12345678; data_operandB = 32'h0F0F0F0F;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midreset result", data_result, 32'h0);
        chk("midreset flags", {29'b0, out_valid, result_zero, op_err}, 32'h0);
        chk("midreset in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("midreset no valid", {31'b0, out_valid}, 32'd0);
        end
        run_op("post reset OR", 3'b001, 32'h0F0F0000, 32'h00F000F0, 32'h0FFF00F0,
               1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b, er;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 5 == 0) ? a : $urandom;
            er = model(op, a, b);
            run_op($sformatf("rand%0d", i), op, a, b, er,
                   (op != 3'b111) && (er == 32'h0), op == 3'b111, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
